// File: rtl/bsg_manycore_endpoint_standard_mo.sv
// Client-side request/response logic of the manycore endpoint with multiple outstanding
// requests: in-order return-info FIFO plus a local amoswap lock array.
module bsg_manycore_endpoint_standard_mo #(
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 28,
    parameter int x_cord_width_p    = 7,
    parameter int y_cord_width_p    = 7,
    parameter int reg_id_width_p    = 5,
    parameter int max_outstanding_p = 4,
    parameter int num_locks_p       = 4,
    localparam int mask_width_lp    = data_width_p / 8,
    localparam int count_width_lp   = $clog2(max_outstanding_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      packet_v_i,
    input  logic [1:0]                packet_op_i,
    input  logic [addr_width_p-1:0]   packet_addr_i,
    input  logic [data_width_p-1:0]   packet_data_i,
    input  logic [mask_width_lp-1:0]  packet_mask_i,
    input  logic [reg_id_width_p-1:0] packet_reg_id_i,
    input  logic [reg_id_width_p-1:0] packet_store_reg_id_i,
    input  logic                      packet_float_wb_i,
    input  logic [x_cord_width_p-1:0] packet_src_x_i,
    input  logic [y_cord_width_p-1:0] packet_src_y_i,
    output logic                      packet_yumi_o,
    output logic                      in_v_o,
    output logic                      in_we_o,
    output logic [addr_width_p-1:0]   in_addr_o,
    output logic [data_width_p-1:0]   in_data_o,
    output logic [mask_width_lp-1:0]  in_mask_o,
    input  logic                      in_yumi_i,
    input  logic                      returning_v_i,
    input  logic [data_width_p-1:0]   returning_data_i,
    output logic                      return_v_o,
    output logic [1:0]                return_pkt_type_o,
    output logic [data_width_p-1:0]   return_data_o,
    output logic [reg_id_width_p-1:0] return_reg_id_o,
    output logic [x_cord_width_p-1:0] return_x_o,
    output logic [y_cord_width_p-1:0] return_y_o,
    output logic [count_width_lp-1:0] outstanding_o,
    output logic                      err_o
);

    localparam int ptr_width_lp  = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int lock_idx_w_lp = (num_locks_p > 1) ? $clog2(num_locks_p) : 1;

    typedef enum logic [1:0] {
        PKT_CREDIT   = 2'd0,
        PKT_INT_WB   = 2'd1,
        PKT_FLOAT_WB = 2'd2
    } pkt_type_e;

    typedef struct packed {
        logic [y_cord_width_p-1:0] src_y;
        logic [x_cord_width_p-1:0] src_x;
        logic [reg_id_width_p-1:0] reg_id;
        pkt_type_e                 pkt_type;
    } ret_info_s;

    ret_info_s                 fifo_q [max_outstanding_p];
    logic [ptr_width_lp-1:0]   head_q, tail_q;
    logic [count_width_lp-1:0] count_q, count_d;
    logic [num_locks_p-1:0]    lock_q;
    logic                      lock_pend_q, lock_old_q, err_q;
    ret_info_s                 lock_info_q;

    logic                     is_amo, full, empty, amo_yumi, enq, pop, proto_err;
    logic [lock_idx_w_lp-1:0] lock_idx;
    ret_info_s                enq_info, head_info;

    function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(max_outstanding_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign is_amo   = (packet_op_i == 2'd3);
    assign full     = (count_q == count_width_lp'(max_outstanding_p));
    assign empty    = (count_q == '0);
    assign lock_idx = (num_locks_p > 1) ? packet_addr_i[lock_idx_w_lp-1:0] : '0;

    // Accept gating uses only registered state, so a freed slot is reusable next cycle.
    assign in_v_o        = reset_n_i & packet_v_i & ~is_amo & ~full & ~lock_pend_q;
    assign amo_yumi      = reset_n_i & packet_v_i & is_amo & empty & ~lock_pend_q;
    assign packet_yumi_o = is_amo ? amo_yumi : (reset_n_i & in_yumi_i);
    assign in_we_o       = (packet_op_i == 2'd1) | (packet_op_i == 2'd2);
    assign in_mask_o     = (packet_op_i == 2'd2) ? packet_mask_i : '1;
    assign in_addr_o     = packet_addr_i;
    assign in_data_o     = packet_data_i;

    assign enq       = in_v_o & in_yumi_i;
    assign pop       = returning_v_i & ~empty;
    assign proto_err = (returning_v_i & empty) | (~is_amo & in_yumi_i & ~in_v_o);
    assign count_d   = count_q + count_width_lp'(enq) - count_width_lp'(pop);

    always_comb begin
        enq_info.src_y    = packet_src_y_i;
        enq_info.src_x    = packet_src_x_i;
        enq_info.reg_id   = (packet_op_i == 2'd2) ? packet_store_reg_id_i : packet_reg_id_i;
        enq_info.pkt_type = PKT_CREDIT;
        if (packet_op_i == 2'd0) begin
            enq_info.pkt_type = packet_float_wb_i ? PKT_FLOAT_WB : PKT_INT_WB;
        end
    end

    assign head_info         = fifo_q[head_q];
    assign return_v_o        = pop | lock_pend_q;
    assign return_pkt_type_o = lock_pend_q ? lock_info_q.pkt_type : head_info.pkt_type;
    assign return_reg_id_o   = lock_pend_q ? lock_info_q.reg_id   : head_info.reg_id;
    assign return_x_o        = lock_pend_q ? lock_info_q.src_x    : head_info.src_x;
    assign return_y_o        = lock_pend_q ? lock_info_q.src_y    : head_info.src_y;
    assign return_data_o     = lock_pend_q ? {{(data_width_p-1){1'b0}}, lock_old_q} : returning_data_i;
    assign outstanding_o     = count_q;
    assign err_o             = err_q;

    // Payload storage needs no reset; validity is tracked by count and pointers.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            fifo_q[tail_q] <= enq_info;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            lock_q      <= '0;
            lock_pend_q <= 1'b0;
            lock_old_q  <= 1'b0;
            lock_info_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if (enq) tail_q <= next_ptr(tail_q);
            if (pop) head_q <= next_ptr(head_q);
            count_q     <= count_d;
            err_q       <= err_q | proto_err;
            lock_pend_q <= amo_yumi;
            if (amo_yumi) begin
                lock_q[lock_idx]     <= packet_data_i[0];
                lock_old_q           <= lock_q[lock_idx];
                lock_info_q.src_y    <= packet_src_y_i;
                lock_info_q.src_x    <= packet_src_x_i;
                lock_info_q.reg_id   <= packet_reg_id_i;
                lock_info_q.pkt_type <= PKT_INT_WB;
            end
        end
    end

endmodule
